// File: rtl/fsm_control_lectura.sv
// Read-side controller of the filter memory interface: streams one window band of
// image rows into the window buffer, hands off to the write FSM and steps the band down.
module fsm_control_lectura #(
    parameter int ANCHO_DIR     = 16,
    parameter int COLUMNAS      = 64,
    parameter int FILAS_VENTANA = 3,
    parameter int FILAS_IMAGEN  = 64,
    parameter int LAT_MEM       = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               i_iniciar_lectura,
    input  logic [ANCHO_DIR-1:0]               i_dir_base_imagen,
    input  logic                               i_bus_escritura_activo,
    input  logic                               i_fila_completa_escrita,
    output logic [ANCHO_DIR-1:0]               o_dir_lectura,
    output logic                               o_leer_mem,
    output logic                               o_dato_valido,
    output logic [$clog2(FILAS_VENTANA)-1:0]   o_fila_ventana,
    output logic [$clog2(COLUMNAS)-1:0]        o_columna_ventana,
    output logic                               o_iniciar_escritura,
    output logic                               o_ocupado,
    output logic                               o_lectura_terminada
);

    localparam int FILA_W = $clog2(FILAS_VENTANA);
    localparam int COL_W  = $clog2(COLUMNAS);
    localparam int FB_W   = $clog2(FILAS_IMAGEN);
    localparam int LAT_W  = (LAT_MEM > 1) ? $clog2(LAT_MEM) : 1;

    localparam logic [COL_W-1:0]  COL_ULT  = COL_W'(COLUMNAS - 1);
    localparam logic [FILA_W-1:0] FILA_ULT = FILA_W'(FILAS_VENTANA - 1);
    localparam logic [FB_W-1:0]   FB_ULT   = FB_W'(FILAS_IMAGEN - FILAS_VENTANA);
    localparam logic [LAT_W-1:0]  LAT_ULT  = LAT_W'(LAT_MEM - 1);

    typedef enum logic [2:0] {
        E_INICIO     = 3'd0,
        E_CARGA      = 3'd1,
        E_LEER       = 3'd2,
        E_DRENAR     = 3'd3,
        E_ESPERA_ESC = 3'd4,
        E_AVANZAR    = 3'd5,
        E_FIN        = 3'd6
    } estado_t;

    estado_t              r_estado,       w_estado_sig;
    logic [ANCHO_DIR-1:0] r_base_img,     w_base_img;
    logic [FB_W-1:0]      r_fila_base,    w_fila_base;
    logic [FILA_W-1:0]    r_fila,         w_fila;
    logic [COL_W-1:0]     r_col,          w_col;
    logic [LAT_W-1:0]     r_cnt_lat,      w_cnt_lat;
    logic                 r_primer_ciclo, w_primer_ciclo;
    logic                 w_leer;
    logic [ANCHO_DIR-1:0] w_desplazamiento;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado       <= E_INICIO;
            r_base_img     <= '0;
            r_fila_base    <= '0;
            r_fila         <= '0;
            r_col          <= '0;
            r_cnt_lat      <= '0;
            r_primer_ciclo <= 1'b0;
        end else begin
            r_estado       <= w_estado_sig;
            r_base_img     <= w_base_img;
            r_fila_base    <= w_fila_base;
            r_fila         <= w_fila;
            r_col          <= w_col;
            r_cnt_lat      <= w_cnt_lat;
            r_primer_ciclo <= w_primer_ciclo;
        end
    end

    always_comb begin
        w_estado_sig        = r_estado;
        w_base_img          = r_base_img;
        w_fila_base         = r_fila_base;
        w_fila              = r_fila;
        w_col               = r_col;
        w_cnt_lat           = r_cnt_lat;
        w_primer_ciclo      = r_primer_ciclo;
        w_leer              = 1'b0;
        o_iniciar_escritura = 1'b0;
        o_lectura_terminada = 1'b0;
        case (r_estado)
            E_INICIO: begin
                if (i_iniciar_lectura) w_estado_sig = E_CARGA;
            end
            E_CARGA: begin
                w_base_img   = i_dir_base_imagen;
                w_fila_base  = '0;
                w_fila       = '0;
                w_col        = '0;
                w_estado_sig = E_LEER;
            end
            E_LEER: begin
                // While the write side owns the bus nothing moves, so the address simply holds.
                w_leer = !i_bus_escritura_activo;
                if (w_leer) begin
                    if (r_col == COL_ULT) begin
                        w_col = '0;
                        if (r_fila == FILA_ULT) begin
                            w_cnt_lat    = '0;
                            w_estado_sig = E_DRENAR;
                        end else begin
                            w_fila = r_fila + 1'b1;
                        end
                    end else begin
                        w_col = r_col + 1'b1;
                    end
                end
            end
            E_DRENAR: begin
                if (r_cnt_lat == LAT_ULT) begin
                    w_primer_ciclo = 1'b1;
                    w_estado_sig   = E_ESPERA_ESC;
                end else begin
                    w_cnt_lat = r_cnt_lat + 1'b1;
                end
            end
            E_ESPERA_ESC: begin
                o_iniciar_escritura = r_primer_ciclo;
                w_primer_ciclo      = 1'b0;
                if (i_fila_completa_escrita) w_estado_sig = E_AVANZAR;
            end
            E_AVANZAR: begin
                if (r_fila_base == FB_ULT) begin
                    w_estado_sig = E_FIN;
                end else begin
                    w_fila_base  = r_fila_base + 1'b1;
                    w_fila       = '0;
                    w_col        = '0;
                    w_estado_sig = E_LEER;
                end
            end
            E_FIN: begin
                o_lectura_terminada = 1'b1;
                w_estado_sig        = E_INICIO;
            end
            default: w_estado_sig = E_INICIO;
        endcase
    end

    // Address arithmetic is done at ANCHO_DIR width so it wraps naturally.
    assign w_desplazamiento = (ANCHO_DIR'(r_fila_base) + ANCHO_DIR'(r_fila)) * ANCHO_DIR'(COLUMNAS)
                            + ANCHO_DIR'(r_col);
    assign o_dir_lectura    = r_base_img + w_desplazamiento;
    assign o_leer_mem       = w_leer;
    assign o_ocupado        = (r_estado != E_INICIO);

    genvar gi;
    generate
        for (gi = 0; gi < LAT_MEM; gi++) begin : g_etapa
            logic              r_valido;
            logic [FILA_W-1:0] r_fila_t;
            logic [COL_W-1:0]  r_col_t;
            logic              w_valido_ent;
            logic [FILA_W-1:0] w_fila_ent;
            logic [COL_W-1:0]  w_col_ent;

            if (gi == 0) begin : g_entrada
                assign w_valido_ent = w_leer;
                assign w_fila_ent   = r_fila;
                assign w_col_ent    = r_col;
            end else begin : g_cadena
                assign w_valido_ent = g_etapa[gi-1].r_valido;
                assign w_fila_ent   = g_etapa[gi-1].r_fila_t;
                assign w_col_ent    = g_etapa[gi-1].r_col_t;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_valido <= 1'b0;
                    r_fila_t <= '0;
                    r_col_t  <= '0;
                end else begin
                    r_valido <= w_valido_ent;
                    r_fila_t <= w_fila_ent;
                    r_col_t  <= w_col_ent;
                end
            end
        end
    endgenerate

    assign o_dato_valido     = g_etapa[LAT_MEM-1].r_valido;
    assign o_fila_ventana    = g_etapa[LAT_MEM-1].r_fila_t;
    assign o_columna_ventana = g_etapa[LAT_MEM-1].r_col_t;

endmodule

// File: tb/tb_fsm_control_lectura.sv
// Scoreboard bench for fsm_control_lectura: stimulus queues expected strobes, tags and
// pulses with their cycle numbers; the monitor compares whenever the DUT presents one.
module tb_fsm_control_lectura;

    localparam int AD  = 16;
    localparam int NC  = 4;
    localparam int FV  = 3;
    localparam int FI  = 5;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ini = 1'b0;
    logic          bus = 1'b0;
    logic          fce = 1'b0;
    logic [AD-1:0] base = 16'h0100;
    logic [AD-1:0] o_dir;
    logic          o_leer, o_dv, o_iw, o_ocup, o_fin;
    logic [1:0]    o_fila, o_col;

    fsm_control_lectura #(
        .ANCHO_DIR(AD), .COLUMNAS(NC), .FILAS_VENTANA(FV), .FILAS_IMAGEN(FI), .LAT_MEM(LAT)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .i_iniciar_lectura      (ini),
        .i_dir_base_imagen      (base),
        .i_bus_escritura_activo (bus),
        .i_fila_completa_escrita(fce),
        .o_dir_lectura          (o_dir),
        .o_leer_mem             (o_leer),
        .o_dato_valido          (o_dv),
        .o_fila_ventana         (o_fila),
        .o_columna_ventana      (o_col),
        .o_iniciar_escritura    (o_iw),
        .o_ocupado              (o_ocup),
        .o_lectura_terminada    (o_fin)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { int v; int c; } ent_t;
    ent_t q_rd[$];
    ent_t q_dv[$];
    int   q_iw[$];
    int   q_fin[$];

    task automatic chk(input string nom, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nom, act, exp, cyc);
        end
    endtask

    task automatic extra(input string nom);
        checks++;
        errors++;
        $display("FAIL %s: unexpected output at cycle %0d (dir 0x%0h tag %0d,%0d)",
                 nom, cyc, o_dir, o_fila, o_col);
    endtask

    // Monitor
    always @(negedge clk) begin
        ent_t e;
        if (o_leer === 1'b1) begin
            if (q_rd.size() == 0) extra("rd_extra");
            else begin
                e = q_rd.pop_front();
                chk("rd_addr", 32'(o_dir), e.v);
                chk("rd_cycle", cyc, e.c);
                $display("read  addr 0x%04h cycle %0d", o_dir, cyc);
            end
        end
        if (o_dv === 1'b1) begin
            if (q_dv.size() == 0) extra("dv_extra");
            else begin
                e = q_dv.pop_front();
                chk("dv_tag", 32'(o_fila) * 256 + 32'(o_col), e.v);
                chk("dv_cycle", cyc, e.c);
                $display("valid tag (%0d,%0d) cycle %0d", o_fila, o_col, cyc);
            end
        end
        if (o_iw === 1'b1) begin
            if (q_iw.size() == 0) extra("iw_extra");
            else begin
                chk("iw_cycle", cyc, q_iw.pop_front());
                $display("iniciar_escritura cycle %0d", cyc);
            end
        end
        if (o_fin === 1'b1) begin
            if (q_fin.size() == 0) extra("fin_extra");
            else begin
                chk("fin_cycle", cyc, q_fin.pop_front());
                $display("lectura_terminada cycle %0d", cyc);
            end
        end
    end

    // Lands just after the posedge that starts cycle t.
    task automatic at(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run(input logic [AD-1:0] b, output int s);
        @(posedge clk);
        #1;
        base = b;
        ini  = 1'b1;
        s    = cyc;
        @(posedge clk);
        #1;
        ini = 1'b0;
    endtask

    // Reads of one band starting at cycle t0, optional stall of st_len cycles before read st_after.
    task automatic push_band(input int b, input int fb, input int t0, input int st_after,
                             input int st_len, input int n_rd, input int n_dv, output int t_iw);
        int tc;
        tc = t0;
        for (int i = 0; i < n_rd; i++) begin
            tc = t0 + i + ((i >= st_after) ? st_len : 0);
            q_rd.push_back('{v: (b + (fb + i / NC) * NC + i % NC) & 16'hFFFF, c: tc});
            if (i < n_dv) q_dv.push_back('{v: (i / NC) * 256 + (i % NC), c: tc + LAT});
        end
        t_iw = tc + 1 + LAT;
    endtask

    task automatic do_reset(input int t);
        at(t);
        reset = 1'b1;
        at(t + 2);
        reset = 1'b0;
    endtask

    task automatic chk_empty(input string nom);
        chk(nom, q_rd.size() + q_dv.size() + q_iw.size() + q_fin.size(), 0);
    endtask

    initial begin
        int s, iw1, iw2, iw3, t0, r1, r2, r3, tfin;

        // Reset with a simultaneous start request: reset must win.
        ini = 1'b1;
        at(2);
        @(negedge clk);
        chk("rst_leer", o_leer, 0);
        chk("rst_dv", o_dv, 0);
        chk("rst_iw", o_iw, 0);
        chk("rst_ocupado", o_ocup, 0);
        chk("rst_fin", o_fin, 0);
        chk("rst_dir", o_dir, 0);
        at(3);
        reset = 1'b0;
        ini   = 1'b0;
        at(5);
        @(negedge clk);
        chk("idle_ocupado", o_ocup, 0);

        // Full image: three bands, second reply in the same cycle as iniciar_escritura.
        start_run(16'h0100, s);
        push_band(16'h0100, 0, s + 2, 99, 0, 12, 12, iw1);
        q_iw.push_back(iw1);
        r1 = iw1 + 1;
        push_band(16'h0100, 1, r1 + 2, 99, 0, 12, 12, iw2);
        q_iw.push_back(iw2);
        r2 = iw2;
        push_band(16'h0100, 2, r2 + 2, 99, 0, 12, 12, iw3);
        q_iw.push_back(iw3);
        r3 = iw3 + 1;
        tfin = r3 + 2;
        q_fin.push_back(tfin);
        at(r1); fce = 1'b1; at(r1 + 1); fce = 1'b0;
        at(r2); fce = 1'b1; at(r2 + 1); fce = 1'b0;
        at(r3); fce = 1'b1; at(r3 + 1); fce = 1'b0;
        at(tfin);
        @(negedge clk);
        chk("fin_ocupado", o_ocup, 1);
        at(tfin + 1);
        @(negedge clk);
        chk("after_fin_ocupado", o_ocup, 0);
        at(tfin + 3);
        chk_empty("q_empty_full");

        // Bus stall after the 5th read.
        start_run(16'h0100, s);
        t0 = s + 2;
        push_band(16'h0100, 0, t0, 5, 3, 12, 12, iw1);
        q_iw.push_back(iw1);
        at(t0 + 5);
        bus = 1'b1;
        for (int k = 0; k < 3; k++) begin
            at(t0 + 5 + k);
            @(negedge clk);
            chk("stall_dir", o_dir, 16'h0105);
            chk("stall_leer", o_leer, 0);
        end
        at(t0 + 8);
        bus = 1'b0;
        do_reset(iw1 + 2);
        at(iw1 + 5);
        chk_empty("q_empty_stall");

        // Stray start and write-done pulses during reads are ignored.
        start_run(16'h0100, s);
        t0 = s + 2;
        push_band(16'h0100, 0, t0, 99, 0, 12, 12, iw1);
        q_iw.push_back(iw1);
        at(t0 + 4);
        ini = 1'b1;
        fce = 1'b1;
        at(t0 + 5);
        ini = 1'b0;
        fce = 1'b0;
        do_reset(iw1 + 2);
        at(iw1 + 5);
        chk_empty("q_empty_ignore");

        // Reset at the 7th read, then a clean restart.
        start_run(16'h0100, s);
        t0 = s + 2;
        push_band(16'h0100, 0, t0, 99, 0, 7, 6, iw1);
        at(t0 + 6);
        reset = 1'b1;
        at(t0 + 7);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_leer", o_leer, 0);
        chk("mid_rst_dv", o_dv, 0);
        chk("mid_rst_ocupado", o_ocup, 0);
        chk("mid_rst_dir", o_dir, 0);
        chk("mid_rst_iw", o_iw, 0);
        at(t0 + 20);
        chk_empty("q_empty_midrst");
        start_run(16'h0100, s);
        push_band(16'h0100, 0, s + 2, 99, 0, 12, 12, iw1);
        q_iw.push_back(iw1);
        do_reset(iw1 + 2);
        at(iw1 + 5);
        chk_empty("q_empty_restart");

        // Address wrap at the top of the 16-bit space.
        start_run(16'hFFFC, s);
        push_band(16'hFFFC, 0, s + 2, 99, 0, 12, 12, iw1);
        q_iw.push_back(iw1);
        do_reset(iw1 + 2);
        at(iw1 + 5);
        chk_empty("q_empty_wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
